// File: rtl/memory_game_pkg.sv
// Shared constants for the memory game engine.
//   state_t       : FSM state codes 0..7, shown directly on state_display
//   LFSR_W/TAPS   : 16-bit Fibonacci LFSR, taps 16,14,13,11
//   max3()        : sizes the shared duration counter
package memory_game_pkg;

  localparam int unsigned STATE_DISP_W = 4;
  localparam int unsigned LFSR_W       = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    APPEND       = 3'd1,
    PLAY_ON      = 3'd2,
    PLAY_GAP     = 3'd3,
    WAIT_KEY     = 3'd4,
    WAIT_RELEASE = 3'd5,
    WON          = 3'd6,
    LOST         = 3'd7
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/memory_game_if.sv
// Player-facing signals of the memory game engine.
//   master : drives start/note_inputs, observes the display outputs (board side)
//   slave  : the engine
interface memory_game_if
  import memory_game_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 4,
  parameter int unsigned LEVEL_W  = 5
);
  logic                    start;
  logic [NUM_KEYS-1:0]     note_inputs;
  logic [NUM_KEYS-1:0]     note_out;
  logic [LEVEL_W-1:0]      level;
  logic [STATE_DISP_W-1:0] state_display;
  logic                    won;
  logic                    lost;

  modport master (
    output start, note_inputs,
    input  note_out, level, state_display, won, lost
  );

  modport slave (
    input  start, note_inputs,
    output note_out, level, state_display, won, lost
  );
endinterface

// File: rtl/memory_game_engine_lfsr16.sv
// 16-bit Fibonacci LFSR stepping every cycle; loads seed while reset is high.
//   clk, reset : clock, synchronous active-high reset
//   seed       : reset value (must be nonzero)
//   q          : low OUT_W bits of the current LFSR state
module lfsr16
  import memory_game_pkg::*;
#(
  parameter int unsigned OUT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  output logic [OUT_W-1:0]  q
);

  logic [LFSR_W-1:0] r_q;
  logic              w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (reset) r_q <= seed;
    else       r_q <= {r_q[LFSR_W-2:0], w_fb};
  end

  assign q = r_q[OUT_W-1:0];

endmodule

// File: rtl/memory_game_engine.sv
// Simon-style memory game: grows a random note sequence one note per round,
// plays it back, scores key presses and reports win/loss.
//   clk, reset : clock, synchronous active-high reset
//   game       : slave side of memory_game_if (start, note_inputs in;
//                note_out, level, state_display, won, lost out)
module memory_game_engine
  import memory_game_pkg::*;
#(
  parameter int unsigned NUM_KEYS     = 4,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned NOTE_CYCLES  = 25000000,
  parameter int unsigned GAP_CYCLES   = 12500000,
  parameter int unsigned RESP_TIMEOUT = 0,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic          clk,
  input  logic          reset,
  memory_game_if.slave  game
);

  localparam int unsigned IDX_W   = $clog2(NUM_KEYS);
  localparam int unsigned LEVEL_W = $clog2(MAX_LEN + 1);
  localparam int unsigned SEQ_AW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned SEQ_D   = 2 ** SEQ_AW;
  localparam int unsigned CNT_MAX = max3(NOTE_CYCLES, GAP_CYCLES, RESP_TIMEOUT);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t              r_state;
  logic [LEVEL_W-1:0]  r_level;
  logic [LEVEL_W-1:0]  r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_KEYS-1:0] r_prev_keys;
  logic [IDX_W-1:0]    r_seq [SEQ_D];

  logic [IDX_W-1:0]    w_rand;
  logic [IDX_W-1:0]    w_cur_note;
  logic [NUM_KEYS-1:0] w_exp_onehot;
  logic                w_press;
  logic                w_released;
  logic                w_last;
  logic                w_note_done;
  logic                w_gap_done;
  logic                w_timeout;

  lfsr16 #(.OUT_W(IDX_W)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .q     (w_rand)
  );

  assign w_cur_note   = r_seq[SEQ_AW'(r_idx)];
  assign w_exp_onehot = NUM_KEYS'(1) << w_cur_note;
  // Rising edge of "any key": keys already held on entry never count.
  assign w_press      = (game.note_inputs != '0) && (r_prev_keys == '0);
  assign w_released   = (game.note_inputs == '0);
  assign w_last       = (r_idx == r_level - LEVEL_W'(1));
  assign w_note_done  = (r_cnt == CNT_W'(NOTE_CYCLES - 1));
  assign w_gap_done   = (r_cnt == CNT_W'(GAP_CYCLES - 1));
  assign w_timeout    = (RESP_TIMEOUT != 0) && (r_cnt == CNT_W'(RESP_TIMEOUT - 1));

  // Sequence storage: deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == APPEND)) r_seq[SEQ_AW'(r_level)] <= w_rand;
  end

  // Main FSM; the duration counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_level     <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_prev_keys <= '0;
    end else begin
      r_prev_keys <= game.note_inputs;
      r_cnt       <= r_cnt + CNT_W'(1);
      case (r_state)
        IDLE: begin
          if (game.start) begin
            r_state <= APPEND;
            r_cnt   <= '0;
          end
        end
        APPEND: begin
          r_level <= r_level + LEVEL_W'(1);
          r_idx   <= '0;
          r_state <= PLAY_ON;
          r_cnt   <= '0;
        end
        PLAY_ON: begin
          if (w_note_done) begin
            r_state <= PLAY_GAP;
            r_cnt   <= '0;
          end
        end
        PLAY_GAP: begin
          if (w_gap_done) begin
            r_cnt <= '0;
            if (r_idx + LEVEL_W'(1) == r_level) begin
              r_idx   <= '0;
              r_state <= WAIT_KEY;
            end else begin
              r_idx   <= r_idx + LEVEL_W'(1);
              r_state <= PLAY_ON;
            end
          end
        end
        WAIT_KEY: begin
          if (w_press) begin
            r_cnt   <= '0;
            r_state <= (game.note_inputs == w_exp_onehot) ? WAIT_RELEASE : LOST;
          end else if (w_timeout) begin
            r_cnt   <= '0;
            r_state <= LOST;
          end
        end
        WAIT_RELEASE: begin
          if (w_released) begin
            r_cnt <= '0;
            if (w_last) begin
              r_state <= (r_level == LEVEL_W'(MAX_LEN)) ? WON : APPEND;
            end else begin
              r_idx   <= r_idx + LEVEL_W'(1);
              r_state <= WAIT_KEY;
            end
          end
        end
        WON, LOST: begin
          if (game.start) begin
            r_level <= '0;
            r_state <= APPEND;
            r_cnt   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Note LEDs; WAIT_RELEASE echoes the keys straight through.
  always_comb begin
    game.note_out = '0;
    case (r_state)
      PLAY_ON, LOST: game.note_out = w_exp_onehot;
      WAIT_RELEASE:  game.note_out = game.note_inputs;
      WON:           game.note_out = '1;
      default:       game.note_out = '0;
    endcase
  end

  assign game.level         = r_level;
  assign game.state_display = STATE_DISP_W'(r_state);
  assign game.won           = (r_state == WON);
  assign game.lost          = (r_state == LOST);

endmodule

// File: tb/tb_memory_game_engine.sv
// Self-checking bench for memory_game_engine (4 keys, MAX_LEN=3, NOTE=2,
// GAP=1, RESP_TIMEOUT=5). An independent LFSR model predicts each new note.
module tb_memory_game_engine;

  localparam int NOTE = 2;
  localparam int GAP  = 1;
  localparam int TMO  = 5;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  exp_seq [3];
  logic [3:0]  sb_q [$];

  memory_game_if #(.NUM_KEYS(4), .LEVEL_W(2)) gif ();

  memory_game_engine #(
    .NUM_KEYS(4), .MAX_LEN(3), .NOTE_CYCLES(NOTE), .GAP_CYCLES(GAP),
    .RESP_TIMEOUT(TMO), .SEED(16'hACE1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .game  (gif)
  );

  always #5 clk = ~clk;

  // Reference LFSR: taps 16,14,13,11, shifted left.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [3:0] oh(input logic [1:0] n);
    logic [3:0] one;
    one = 4'b0001;
    return one << n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", what, cyc, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int st, input int lvl, input logic [3:0] note);
    #1;
    chk({tag, ".state"}, 32'(gif.state_display), 32'(st));
    chk({tag, ".level"}, 32'(gif.level), 32'(lvl));
    chk({tag, ".note"},  32'(gif.note_out), 32'(note));
    chk({tag, ".won"},   32'(gif.won), 32'(st == 6));
    chk({tag, ".lost"},  32'(gif.lost), 32'(st == 7));
  endtask

  // mode: 0 correct replay, 1 wrong press at position 0 (wk, or auto if 0),
  //       2 timeout with no key, 3 timeout with a key held from playback.
  task automatic run_round(input int L, input int mode, input logic [3:0] wk);
    logic [3:0] e;
    logic [3:0] bad;
    logic [1:0] other;
    gif.start = 1'b0;
    gif.note_inputs = 4'h0;
    expect_out("append", 1, L - 1, 4'h0);
    exp_seq[L-1] = m_lfsr[1:0];
    for (int i = 0; i < L; i++) sb_q.push_back(oh(exp_seq[i]));
    tick();
    for (int i = 0; i < L; i++) begin
      e = sb_q.pop_front();
      for (int c = 0; c < NOTE; c++) begin
        expect_out("play_on", 2, L, e);
        tick();
      end
      for (int c = 0; c < GAP; c++) begin
        if (mode == 3 && i == L - 1) gif.note_inputs = oh(exp_seq[0]);
        expect_out("play_gap", 3, L, 4'h0);
        tick();
      end
    end
    if (mode >= 2) begin
      for (int c = 0; c < TMO; c++) begin
        expect_out("wait_tmo", 4, L, 4'h0);
        tick();
      end
      expect_out("tmo_lost", 7, L, oh(exp_seq[0]));
      gif.note_inputs = 4'h0;
      return;
    end
    for (int i = 0; i < L; i++) begin
      gif.note_inputs = 4'h0;
      expect_out("wait_key", 4, L, 4'h0);
      tick();
      if (mode == 1 && i == 0) begin
        other = exp_seq[0] + 2'd1;
        bad = (wk != 4'h0) ? wk : oh(other);
        gif.note_inputs = bad;
        expect_out("bad_press", 4, L, 4'h0);
        tick();
        gif.note_inputs = 4'h0;
        expect_out("bad_lost", 7, L, oh(exp_seq[0]));
        return;
      end
      gif.note_inputs = oh(exp_seq[i]);
      expect_out("press", 4, L, 4'h0);
      tick();
      gif.note_inputs = 4'h0;
      expect_out("release", 5, L, 4'h0);
      tick();
    end
  endtask

  typedef struct {
    logic start;
    int   key_sel;   // 0 none, 1 expected note of position 0
    int   st;
    int   lvl;
    int   note_sel;  // 0 dark, 1 expected note, 2 all on, 3 echo of keys
    bit   cap;       // record the new note from the LFSR model
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [3:0] en;
    vecs[0] = '{1'b1, 0, 0, 0, 0, 1'b0};  // IDLE, start requested
    vecs[1] = '{1'b0, 0, 1, 0, 0, 1'b1};  // APPEND
    vecs[2] = '{1'b0, 0, 2, 1, 1, 1'b0};  // note lit
    vecs[3] = '{1'b0, 0, 2, 1, 1, 1'b0};
    vecs[4] = '{1'b0, 0, 3, 1, 0, 1'b0};  // gap
    vecs[5] = '{1'b1, 0, 4, 1, 0, 1'b0};  // start ignored in WAIT_KEY
    vecs[6] = '{1'b1, 0, 4, 1, 0, 1'b0};
    vecs[7] = '{1'b0, 1, 4, 1, 0, 1'b0};  // correct press appears
    vecs[8] = '{1'b0, 1, 5, 1, 3, 1'b0};  // held: echoed
    vecs[9] = '{1'b0, 0, 5, 1, 3, 1'b0};  // released

    reset = 1'b1;
    gif.start = 1'b0;
    gif.note_inputs = 4'h0;
    repeat (3) tick();
    expect_out("reset", 0, 0, 4'h0);
    reset = 1'b0;
    tick();

    // Round 1 of the first game, cycle by cycle.
    for (int r = 0; r < 10; r++) begin
      gif.start = vecs[r].start;
      gif.note_inputs = (vecs[r].key_sel == 1) ? oh(exp_seq[0]) : 4'h0;
      if (vecs[r].cap) exp_seq[0] = m_lfsr[1:0];
      case (vecs[r].note_sel)
        1:       en = oh(exp_seq[0]);
        2:       en = 4'hF;
        3:       en = gif.note_inputs;
        default: en = 4'h0;
      endcase
      expect_out($sformatf("vec%0d", r), vecs[r].st, vecs[r].lvl, en);
      tick();
    end

    run_round(2, 0, 4'h0);
    run_round(3, 0, 4'h0);
    expect_out("won", 6, 3, 4'hF);

    // New game from WON, then wrong key in round 2 position 0.
    gif.start = 1'b1; tick();
    run_round(1, 0, 4'h0);
    run_round(2, 1, 4'h0);

    // Two keys at once.
    gif.start = 1'b1; tick();
    run_round(1, 1, 4'b0011);

    // Timeout with no key, then with a key held from playback.
    gif.start = 1'b1; tick();
    run_round(1, 2, 4'h0);
    gif.start = 1'b1; tick();
    run_round(1, 3, 4'h0);

    // Reset during playback.
    gif.start = 1'b1; tick();
    gif.start = 1'b0;
    expect_out("r1_append", 1, 0, 4'h0);
    exp_seq[0] = m_lfsr[1:0];
    tick();
    expect_out("r1_play", 2, 1, oh(exp_seq[0]));
    reset = 1'b1;
    tick();
    expect_out("r1_reset", 0, 0, 4'h0);
    reset = 1'b0;
    tick();

    // Reset during response, with start and a key also asserted.
    gif.start = 1'b1; tick();
    gif.start = 1'b0;
    expect_out("r2_append", 1, 0, 4'h0);
    exp_seq[0] = m_lfsr[1:0];
    tick();
    repeat (NOTE + GAP) tick();
    expect_out("r2_wait", 4, 1, 4'h0);
    reset = 1'b1;
    gif.start = 1'b1;
    gif.note_inputs = oh(exp_seq[0]);
    tick();
    expect_out("r2_reset", 0, 0, 4'h0);
    reset = 1'b0;
    gif.start = 1'b0;
    gif.note_inputs = 4'h0;
    tick();

    // Play on after reset: LFSR must have been reseeded.
    gif.start = 1'b1; tick();
    run_round(1, 0, 4'h0);
    expect_out("post_reset", 1, 1, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
